// File: rtl/reg_file_2w2r.sv
// rtl/reg_file_2w2r.sv - two-write, two-read register file with clear sweep
//
// Register file for dual-issue / split-writeback pipelines. Two results can
// retire per cycle. After reset, a sequential sweep zeroes every entry. Writes
// are accepted only once the sweep has finished. Reads are combinational. They
// return 0 until the sweep has finished. The file can forward same-cycle write
// data to the read ports, and entry 0 can be made a hard-wired zero.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous reset, active-high; restarts the clear sweep
//   ra0, ra1   read addresses
//   rd0, rd1   read data (combinational)
//   wa0, wd0, we0  write port 0
//   wa1, wd1, we1  write port 1 (wins over port 0 on the same address)
//   ready      1 = clear sweep done, writes accepted, reads valid

module reg_file_2w2r #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ra0,
  input  logic [ADDR_WIDTH-1:0] ra1,
  output logic [DATA_WIDTH-1:0] rd0,
  output logic [DATA_WIDTH-1:0] rd1,
  input  logic [ADDR_WIDTH-1:0] wa0,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] wa1,
  input  logic [DATA_WIDTH-1:0] wd1,
  input  logic                  we1,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clear_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // A write port is "live" only in RUN and, with the zero register enabled,
  // only when it does not target entry 0. The same qualified enables drive
  // both the array update and the bypass, so a discarded write is never
  // forwarded.
  logic                    w0_live, w1_live;

  assign w0_live = we0 && ready && !((ZERO_REG_EN != 0) && (wa0 == '0));
  assign w1_live = we1 && ready && !((ZERO_REG_EN != 0) && (wa1 == '0));

  // ---------------------------------------------------------------------------
  // Sweep / run FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_we = 1'b0;
    ready    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clear_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // The edge that zeroes the last entry is also the edge that enters RUN.
        if (cnt_q == LAST_ADDR) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // The reset edge itself writes nothing. The sweep owns the array while
  // clearing. Port 1 is applied after port 0, so it wins on an address
  // collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) begin
        mem[cnt_q] <= '0;
      end else begin
        if (w0_live) begin
          mem[wa0] <= wd0;
        end
        if (w1_live) begin
          mem[wa1] <= wd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Priority: not ready -> 0, zero register -> 0, port 1 bypass,
  // port 0 bypass, stored value.
  always_comb begin
    rd0 = '0;
    if (!ready) begin
      rd0 = '0;
    end else if ((ZERO_REG_EN != 0) && (ra0 == '0)) begin
      rd0 = '0;
    end else if ((BYPASS_EN != 0) && w1_live && (wa1 == ra0)) begin
      rd0 = wd1;
    end else if ((BYPASS_EN != 0) && w0_live && (wa0 == ra0)) begin
      rd0 = wd0;
    end else begin
      rd0 = mem[ra0];
    end
  end

  always_comb begin
    rd1 = '0;
    if (!ready) begin
      rd1 = '0;
    end else if ((ZERO_REG_EN != 0) && (ra1 == '0)) begin
      rd1 = '0;
    end else if ((BYPASS_EN != 0) && w1_live && (wa1 == ra1)) begin
      rd1 = wd1;
    end else if ((BYPASS_EN != 0) && w0_live && (wa0 == ra1)) begin
      rd1 = wd0;
    end else begin
      rd1 = mem[ra1];
    end
  end

endmodule
